cmd_frame_ctrl: RTL

Command sequencer in the REF_CLK domain, between the synchronised UART RX byte stream and the register file / ALU. It decodes the frame opcodes:
- 0xAA: register write
- 0xBB: register read
- 0xCC: ALU operation with operands
- 0xDD: ALU operation without operands

It drives the register-file and ALU control strobes and pushes response bytes into the TX async FIFO. It also adds an inter-byte timeout and an explicit illegal-opcode flag.

---
 rtl/sys_ctrl_pkg.sv | 34 +++
 rtl/frame_timeout_cnt.sv | 42 ++++
 rtl/cmd_frame_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the command frame controller.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file addresses that hold the ALU operands
  localparam int unsigned REG_A = 0;
  localparam int unsigned REG_B = 1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_A    = 4'd5,
    ST_ALU_B    = 4'd6,
    ST_ALU_FN   = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LSB   = 4'd9,
    ST_TX_MSB   = 4'd10,
    ST_TX_RD    = 4'd11
  } state_e;

  // States that are waiting on the next RX byte of a frame (timeout applies)
  function automatic logic is_frame_state(input state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_ALU_A)   || (s == ST_ALU_B)   || (s == ST_ALU_FN);
  endfunction

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte timeout counter: clears on demand, counts while enabled, flags the limit.
module frame_timeout_cnt #(
  parameter int unsigned CNT_WIDTH   = 12,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYC - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;

  // Next count; saturates at the limit, done tracks the registered count exactly
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    done_d = (cnt_d == LIMIT);
  end

  // Counter and done flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Command frame sequencer: decodes RX frames, strobes regfile/ALU, pushes TX responses.
module cmd_frame_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  parameter int unsigned CNT_WIDTH     = 12
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     RD_DATA_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]    ADDRESS,
  output logic                     WR_EN,
  output logic                     RD_EN,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CMD_ERR
);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    address_q, address_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [3:0]               alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic [ALU_OUT_WIDTH-1:0] resp_q, resp_d;
  logic wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
  logic clk_en_q, clk_en_d, tx_vld_q, tx_vld_d, cmd_err_q, cmd_err_d;
  logic in_frame_c, tmo_done;

  assign in_frame_c = is_frame_state(state_q);

  // Counter runs only while a frame waits for its next byte
  frame_timeout_cnt #(
    .CNT_WIDTH  (CNT_WIDTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST),
    .clear_i(!in_frame_c || RX_D_VLD),
    .en_i   (in_frame_c),
    .done_o (tmo_done)
  );

  // Next-state and next-output decode; a byte arriving on the timeout cycle wins
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    resp_d    = resp_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    cmd_err_d = 1'b0;
    if (in_frame_c && !RX_D_VLD && tmo_done) begin
      state_d   = ST_IDLE;
      cmd_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (RX_D_VLD) begin
          case (RX_P_DATA)
            DATA_WIDTH'(CMD_WR):      state_d = ST_WR_ADDR;
            DATA_WIDTH'(CMD_RD):      state_d = ST_RD_ADDR;
            DATA_WIDTH'(CMD_ALU_OP):  state_d = ST_ALU_A;
            DATA_WIDTH'(CMD_ALU_NOP): state_d = ST_ALU_FN;
            default:                  cmd_err_d = 1'b1;
          endcase
        end
        ST_WR_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = ST_WR_DATA;
        end
        ST_WR_DATA: if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_RD_ADDR: if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
          state_d   = ST_RD_WAIT;
        end
        ST_RD_WAIT: if (RD_DATA_VLD) begin
          resp_d  = ALU_OUT_WIDTH'(RD_DATA);
          state_d = ST_TX_RD;
        end
        ST_ALU_A: if (RX_D_VLD) begin
          address_d = ADDR_WIDTH'(REG_A);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_B;
        end
        ST_ALU_B: if (RX_D_VLD) begin
          address_d = ADDR_WIDTH'(REG_B);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_FN;
        end
        ST_ALU_FN: if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
        ST_ALU_WAIT: if (ALU_OUT_VLD) begin
          resp_d  = ALU_OUT;
          state_d = ST_TX_LSB;
        end
        ST_TX_RD: if (!FIFO_FULL) begin
          tx_data_d = resp_q[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = ST_IDLE;
        end
        ST_TX_LSB: if (!FIFO_FULL) begin
          tx_data_d = resp_q[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = ST_TX_MSB;
        end
        ST_TX_MSB: if (!FIFO_FULL) begin
          tx_data_d = resp_q[ALU_OUT_WIDTH-1 -: DATA_WIDTH];
          tx_vld_d  = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    clk_en_d = (state_d == ST_ALU_FN) || (state_d == ST_ALU_WAIT);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      address_q <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      tx_data_q <= '0;
      resp_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      tx_data_q <= tx_data_d;
      resp_q    <= resp_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      tx_vld_q  <= tx_vld_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign ADDRESS   = address_q;
  assign WR_EN     = wr_en_q;
  assign RD_EN     = rd_en_q;
  assign WR_DATA   = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = cmd_err_q;

endmodule
